simt_reconv_pc: RTL and testbench
=================================

Name: simt_reconv_pc

Overview:
- Successor to the per-block program counter. Computes the next PC and drives the active thread mask for one block.
- Supports real branch divergence. A BRnzp with mixed per-thread outcomes splits the block: the taken path runs first, and the not-taken path is parked on a parametrised reconvergence stack.
- SSY/SYNC pairs bound divergent regions.
- Sits between the decoder/scheduler and the per-thread ALU/LSU enables, in place of the single-PC unit.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, PC width.
- DATA_MEM_DATA_BITS, 8, immediate width; the immediate is truncated or zero-extended to the PC width.
- THREADS_PER_BLOCK, 4, number of threads and mask width (T).
- STACK_DEPTH, 4, number of reconvergence stack entries (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_state  in  4  scheduler state; 4'b0110 = EXECUTE, 4'b0111 = UPDATE.
- decoded_pc_mux  in  1  BRnzp instruction.
- decoded_jump  in  1  unconditional JMP.
- decoded_ssy  in  1  SSY: open a divergent region.
- decoded_sync  in  1  SYNC: reconvergence point.
- decoded_nzp  in  3  branch condition mask.
- decoded_immediate  in  DATA_MEM_DATA_BITS  branch/jump target.
- nzp  in  3*T  per-thread NZP flags; thread i occupies bits [3i+2:3i].
- current_pc  out  PROGRAM_MEM_ADDR_BITS  PC of the instruction being executed.
- next_pc  out  PROGRAM_MEM_ADDR_BITS  PC computed in EXECUTE.
- thread_mask  out  T  active threads; 1 = enabled.
- stack_depth  out  $clog2(STACK_DEPTH+1)  number of occupied entries.
- stack_overflow  out  1  sticky: a push was attempted while full.
- stack_underflow  out  1  sticky: SYNC was issued while the stack was empty.

Behaviour:
- Reset (reset==0, asynchronous): current_pc=0, next_pc=0, thread_mask=all ones, stack_depth=0, both flags=0, stack contents don't-care.
- Stack entry format: {kind, pc, mask}, where kind is RECONV or DIVERGE.
- Per-thread match: m[i] = |(nzp[i] & decoded_nzp).
- Derived masks: TK = thread_mask & m, NT = thread_mask & ~m.
- EXECUTE cycle:
  - next_pc is registered.
  - The pending stack/mask action is latched.
  - Decode priority: pc_mux > jump > ssy > sync > default.
- UPDATE cycle:
  - current_pc <= next_pc.
  - The latched stack push/pop and mask change commit here.
  - All outputs therefore reflect the instruction one UPDATE after its EXECUTE.
- Any other core_state: all state holds.
- BR uniform (TK==thread_mask, including thread_mask==0): next_pc=imm; no stack change.
- BR none (TK==0 and thread_mask!=0): next_pc=pc+1.
- BR mixed, stack not full:
  - Push DIVERGE{pc+1, NT}.
  - thread_mask<=TK.
  - next_pc=imm.
- BR mixed, stack full:
  - stack_overflow<=1.
  - No push; mask unchanged.
  - next_pc=pc+1 (fallthrough).
- JMP: next_pc=imm; mask and stack unchanged.
- SSY, stack not full: push RECONV{imm, thread_mask}; next_pc=pc+1. The pc field is recorded but not used for control.
- SSY, stack full: stack_overflow<=1; no push; next_pc=pc+1.
- SYNC, top is DIVERGE: pop; thread_mask<=top.mask; next_pc=top.pc (switch to the parked path).
- SYNC, top is RECONV: pop; thread_mask<=top.mask (reconverge); next_pc=pc+1.
- SYNC, stack empty: stack_underflow<=1; next_pc=pc+1; mask unchanged.
- Default instruction: next_pc=pc+1.
- PC arithmetic: pc+1 wraps modulo 2^PROGRAM_MEM_ADDR_BITS (all ones -> 0).
- Depth accounting: push and pop each change stack_depth by exactly 1. Push and pop never occur in the same cycle because each instruction has a single action.
- Nesting: supported up to STACK_DEPTH total entries (one SSY region with a single divergence uses 2).
- Sticky flags clear only on reset.
- Reset asserted mid-operation (any state): immediate return to reset values; stack discarded.

Test Plan:
- Reset, then 3 default EXECUTE/UPDATE pairs -> current_pc=3, thread_mask=4'b1111, depth=0.
- At pc=2: SSY (imm=9), then BRnzp nzp=3'b100, imm=7, with thread flags N,Z,N,P:
  - After the BR UPDATE: current_pc=7, thread_mask=4'b0101, depth=2.
  - SYNC at 9: current_pc=4, mask=4'b1010, depth=1.
  - Second SYNC at 9: current_pc=10, mask=4'b1111, depth=0.
- BRnzp where all thread flags are Z and nzp=3'b010, imm=20 -> current_pc=20, mask unchanged, depth unchanged. Same instruction with nzp=3'b100 -> current_pc=pc+1.
- STACK_DEPTH=4, five SSY in a row -> depth=4, stack_overflow=1 after the fifth, current_pc advances by 1 each time.
- SYNC at depth 0 -> stack_underflow=1, current_pc=pc+1, mask=4'b1111.
- Assert reset low mid-EXECUTE during a diverged region at depth 2 -> outputs return to reset values asynchronously, before the next clk edge. Post-reset SYNC sets underflow.

Source files
------------

// File: rtl/simt_reconv_pc.sv
// simt_reconv_pc: per-block PC with SSY/SYNC reconvergence stack.
// Computes next_pc in EXECUTE; commits PC, mask and stack in UPDATE.
//
// Ports:
//   clk, reset (async, active-low)
//   core_state            scheduler state (0110 EXECUTE, 0111 UPDATE)
//   decoded_*             decoded BRnzp/JMP/SSY/SYNC, nzp mask, target
//   nzp                   per-thread NZP flags, 3 bits per thread
//   current_pc, next_pc   PC of the executing and following instruction
//   thread_mask           active thread enables
//   stack_depth           occupied reconvergence entries
//   stack_overflow/_underflow  sticky stack error flags
module simt_reconv_pc #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int STACK_DEPTH           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   core_state,
  input  logic                         decoded_pc_mux,
  input  logic                         decoded_jump,
  input  logic                         decoded_ssy,
  input  logic                         decoded_sync,
  input  logic [2:0]                   decoded_nzp,
  input  logic [DATA_MEM_DATA_BITS-1:0] decoded_immediate,
  input  logic [3*THREADS_PER_BLOCK-1:0] nzp,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [THREADS_PER_BLOCK-1:0] thread_mask,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int AB = PROGRAM_MEM_ADDR_BITS;
  localparam int DB = DATA_MEM_DATA_BITS;
  localparam int T  = THREADS_PER_BLOCK;
  localparam int SD = STACK_DEPTH;
  localparam int DW = $clog2(SD + 1);
  localparam int IW = (SD > 1) ? $clog2(SD) : 1;
  localparam int WW = (AB > DB) ? AB : DB;

  localparam logic [3:0] ST_EXEC = 4'b0110;
  localparam logic [3:0] ST_UPD  = 4'b0111;

  typedef enum logic {
    K_RECONV  = 1'b0,
    K_DIVERGE = 1'b1
  } kind_e;

  logic [AB-1:0] r_pc;
  logic [AB-1:0] r_npc;
  logic [T-1:0]  r_mask;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_udf;

  logic          r_p_push;
  logic          r_p_pop;
  kind_e         r_p_kind;
  logic [AB-1:0] r_p_epc;
  logic [T-1:0]  r_p_emask;
  logic          r_p_mwr;
  logic [T-1:0]  r_p_mval;
  logic          r_p_ovf;
  logic          r_p_udf;

  kind_e         r_stk_kind [SD];
  logic [AB-1:0] r_stk_pc   [SD];
  logic [T-1:0]  r_stk_mask [SD];

  logic          w_exec;
  logic          w_upd;
  logic          w_full;
  logic          w_empty;
  logic [IW-1:0] w_top;
  logic [IW-1:0] w_wr;
  logic [AB-1:0] w_pc1;
  logic [WW-1:0] w_imm_w;
  logic [AB-1:0] w_imm;
  logic [T-1:0]  w_m;
  logic [T-1:0]  w_tk;
  logic [T-1:0]  w_nt;

  logic [AB-1:0] w_npc;
  logic          w_push;
  logic          w_pop;
  kind_e         w_kind;
  logic [AB-1:0] w_epc;
  logic [T-1:0]  w_emask;
  logic          w_mwr;
  logic [T-1:0]  w_mval;
  logic          w_ovf;
  logic          w_udf;

  assign w_exec  = (core_state == ST_EXEC);
  assign w_upd   = (core_state == ST_UPD);
  assign w_full  = (r_depth == DW'(SD));
  assign w_empty = (r_depth == '0);
  assign w_top   = IW'(r_depth - 1'b1);
  assign w_wr    = IW'(r_depth);
  assign w_pc1   = r_pc + 1'b1;
  assign w_imm_w = WW'(decoded_immediate);
  assign w_imm   = w_imm_w[AB-1:0];

  always_comb begin
    w_m = '0;
    for (int i = 0; i < T; i++)
      w_m[i] = |(nzp[3*i +: 3] & decoded_nzp);
  end

  assign w_tk = r_mask & w_m;
  assign w_nt = r_mask & ~w_m;

  // One action per instruction; priority follows decode order.
  always_comb begin
    w_npc   = w_pc1;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_kind  = K_RECONV;
    w_epc   = '0;
    w_emask = '0;
    w_mwr   = 1'b0;
    w_mval  = r_mask;
    w_ovf   = 1'b0;
    w_udf   = 1'b0;
    if (decoded_pc_mux) begin
      if (w_tk == r_mask) begin
        w_npc = w_imm;
      end else if (w_tk == '0) begin
        w_npc = w_pc1;
      end else if (!w_full) begin
        w_push  = 1'b1;
        w_kind  = K_DIVERGE;
        w_epc   = w_pc1;
        w_emask = w_nt;
        w_mwr   = 1'b1;
        w_mval  = w_tk;
        w_npc   = w_imm;
      end else begin
        w_ovf = 1'b1;
      end
    end else if (decoded_jump) begin
      w_npc = w_imm;
    end else if (decoded_ssy) begin
      if (!w_full) begin
        w_push  = 1'b1;
        w_kind  = K_RECONV;
        w_epc   = w_imm;
        w_emask = r_mask;
      end else begin
        w_ovf = 1'b1;
      end
    end else if (decoded_sync) begin
      if (w_empty) begin
        w_udf = 1'b1;
      end else begin
        w_pop  = 1'b1;
        w_mwr  = 1'b1;
        w_mval = r_stk_mask[w_top];
        if (r_stk_kind[w_top] == K_DIVERGE)
          w_npc = r_stk_pc[w_top];
      end
    end
  end

  // Stack contents carry no reset; depth alone marks validity.
  always_ff @(posedge clk) begin
    if (w_upd && r_p_push) begin
      r_stk_kind[w_wr] <= r_p_kind;
      r_stk_pc[w_wr]   <= r_p_epc;
      r_stk_mask[w_wr] <= r_p_emask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_npc     <= '0;
      r_mask    <= '1;
      r_depth   <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_p_push  <= 1'b0;
      r_p_pop   <= 1'b0;
      r_p_kind  <= K_RECONV;
      r_p_epc   <= '0;
      r_p_emask <= '0;
      r_p_mwr   <= 1'b0;
      r_p_mval  <= '0;
      r_p_ovf   <= 1'b0;
      r_p_udf   <= 1'b0;
    end else if (w_exec) begin
      r_npc     <= w_npc;
      r_p_push  <= w_push;
      r_p_pop   <= w_pop;
      r_p_kind  <= w_kind;
      r_p_epc   <= w_epc;
      r_p_emask <= w_emask;
      r_p_mwr   <= w_mwr;
      r_p_mval  <= w_mval;
      r_p_ovf   <= w_ovf;
      r_p_udf   <= w_udf;
    end else if (w_upd) begin
      r_pc <= r_npc;
      if (r_p_push)
        r_depth <= r_depth + 1'b1;
      else if (r_p_pop)
        r_depth <= r_depth - 1'b1;
      if (r_p_mwr)
        r_mask <= r_p_mval;
      if (r_p_ovf)
        r_ovf <= 1'b1;
      if (r_p_udf)
        r_udf <= 1'b1;
      // Clear so a repeated UPDATE cannot commit twice.
      r_p_push <= 1'b0;
      r_p_pop  <= 1'b0;
      r_p_mwr  <= 1'b0;
      r_p_ovf  <= 1'b0;
      r_p_udf  <= 1'b0;
    end
  end

  assign current_pc      = r_pc;
  assign next_pc         = r_npc;
  assign thread_mask     = r_mask;
  assign stack_depth     = r_depth;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_udf;

endmodule

// File: tb/tb_simt_reconv_pc.sv
// tb_simt_reconv_pc: directed and random stimulus for simt_reconv_pc
// against a queue-based reference model of the stack rules.
module tb_simt_reconv_pc;

  localparam int AB = 8;
  localparam int DB = 8;
  localparam int T  = 4;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);

  logic          clk;
  logic          rst_n;
  logic [3:0]    cs;
  logic          d_pm;
  logic          d_jm;
  logic          d_ss;
  logic          d_sy;
  logic [2:0]    d_nzp;
  logic [DB-1:0] d_imm;
  logic [3*T-1:0] t_nzp;
  logic [AB-1:0] o_cpc;
  logic [AB-1:0] o_npc;
  logic [T-1:0]  o_mask;
  logic [DW-1:0] o_depth;
  logic          o_ovf;
  logic          o_udf;

  simt_reconv_pc #(
    .PROGRAM_MEM_ADDR_BITS(AB),
    .DATA_MEM_DATA_BITS(DB),
    .THREADS_PER_BLOCK(T),
    .STACK_DEPTH(SD)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .core_state(cs),
    .decoded_pc_mux(d_pm),
    .decoded_jump(d_jm),
    .decoded_ssy(d_ss),
    .decoded_sync(d_sy),
    .decoded_nzp(d_nzp),
    .decoded_immediate(d_imm),
    .nzp(t_nzp),
    .current_pc(o_cpc),
    .next_pc(o_npc),
    .thread_mask(o_mask),
    .stack_depth(o_depth),
    .stack_overflow(o_ovf),
    .stack_underflow(o_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         div;
    logic [7:0] pc;
    logic [3:0] mk;
  } ent_t;

  ent_t       stk[$];
  logic [7:0] m_pc;
  logic [3:0] m_mask;
  bit         m_ovf;
  bit         m_udf;

  int n_chk;
  int n_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".cpc"}, 32'(o_cpc), 32'(m_pc));
    chk({tag, ".npc"}, 32'(o_npc), 32'(m_pc));
    chk({tag, ".mask"}, 32'(o_mask), 32'(m_mask));
    chk({tag, ".dep"}, 32'(o_depth),
        32'(stk.size()));
    chk({tag, ".ovf"}, 32'(o_ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(o_udf), 32'(m_udf));
  endtask

  task automatic mdl_reset();
    stk.delete();
    m_pc   = '0;
    m_mask = '1;
    m_ovf  = 0;
    m_udf  = 0;
  endtask

  task automatic mdl_apply(input logic pm, jm, ss, sy,
                           input logic [2:0] dn,
                           input logic [7:0] imm,
                           input logic [11:0] nz);
    logic [3:0] m, tk, nt;
    logic [7:0] pc1, npc;
    ent_t e;
    for (int i = 0; i < T; i++)
      m[i] = |(nz[3*i +: 3] & dn);
    tk  = m_mask & m;
    nt  = m_mask & ~m;
    pc1 = m_pc + 8'd1;
    npc = pc1;
    if (pm) begin
      if (tk == m_mask) npc = imm;
      else if (tk == 0) npc = pc1;
      else if (stk.size() < SD) begin
        e.div = 1; e.pc = pc1; e.mk = nt;
        stk.push_back(e);
        m_mask = tk;
        npc = imm;
      end else m_ovf = 1;
    end else if (jm) begin
      npc = imm;
    end else if (ss) begin
      if (stk.size() < SD) begin
        e.div = 0; e.pc = imm; e.mk = m_mask;
        stk.push_back(e);
      end else m_ovf = 1;
    end else if (sy) begin
      if (stk.size() == 0) m_udf = 1;
      else begin
        e = stk.pop_back();
        m_mask = e.mk;
        if (e.div) npc = e.pc;
      end
    end
    m_pc = npc;
  endtask

  task automatic idle_state(output logic [3:0] v);
    do v = 4'($urandom_range(0, 15));
    while (v == 4'b0110 || v == 4'b0111);
  endtask

  task automatic do_reset(input string tag);
    cs = 4'h0;
    rst_n = 1'b0;
    #2;
    mdl_reset();
    chk_all(tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic instr(input string tag,
                       input logic pm, jm, ss, sy,
                       input logic [2:0] dn,
                       input logic [7:0] imm,
                       input logic [11:0] nz,
                       input bit idle);
    logic [3:0] v;
    d_pm = pm; d_jm = jm; d_ss = ss; d_sy = sy;
    d_nzp = dn; d_imm = imm; t_nzp = nz;
    cs = 4'b0110;
    @(posedge clk); #1;
    if (idle) begin
      idle_state(v);
      cs = v;
      @(posedge clk); #1;
    end
    cs = 4'b0111;
    @(posedge clk); #1;
    idle_state(v);
    cs = v;
    mdl_apply(pm, jm, ss, sy, dn, imm, nz);
    chk_all(tag);
  endtask

  task automatic dflt(input string tag);
    instr(tag, 0, 0, 0, 0, 3'b000, 8'h00,
          12'h000, 0);
  endtask

  // Thread flags N,Z,N,P for threads 0..3.
  localparam logic [11:0] NZNP = {3'b001, 3'b100,
                                  3'b010, 3'b100};
  localparam logic [11:0] ALLZ = {4{3'b010}};

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    cs = 4'h0;
    d_pm = 0; d_jm = 0; d_ss = 0; d_sy = 0;
    d_nzp = '0; d_imm = '0; t_nzp = '0;
    @(posedge clk); #1;
    do_reset("rst0");

    for (int i = 0; i < 3; i++) dflt("dflt");
    chk("tp_pc3", 32'(o_cpc), 32'd3);
    chk("tp_m3", 32'(o_mask), 32'hf);

    do_reset("rst1");
    dflt("d0");
    dflt("d1");
    instr("ssy", 0, 0, 1, 0, 3'b000, 8'd9,
          NZNP, 0);
    instr("brmix", 1, 0, 0, 0, 3'b100, 8'd7,
          NZNP, 0);
    chk("tp_brpc", 32'(o_cpc), 32'd7);
    chk("tp_brm", 32'(o_mask), 32'h5);
    chk("tp_brd", 32'(o_depth), 32'd2);
    dflt("d7");
    dflt("d8");
    instr("sync1", 0, 0, 0, 1, 3'b000, 8'h00,
          NZNP, 1);
    chk("tp_s1pc", 32'(o_cpc), 32'd4);
    chk("tp_s1m", 32'(o_mask), 32'ha);
    chk("tp_s1d", 32'(o_depth), 32'd1);
    for (int i = 0; i < 5; i++) dflt("d4_8");
    instr("sync2", 0, 0, 0, 1, 3'b000, 8'h00,
          NZNP, 0);
    chk("tp_s2pc", 32'(o_cpc), 32'd10);
    chk("tp_s2m", 32'(o_mask), 32'hf);
    chk("tp_s2d", 32'(o_depth), 32'd0);

    instr("bruni", 1, 0, 0, 0, 3'b010, 8'd20,
          ALLZ, 0);
    chk("tp_unipc", 32'(o_cpc), 32'd20);
    instr("brnone", 1, 0, 0, 0, 3'b100, 8'd20,
          ALLZ, 0);
    chk("tp_nonepc", 32'(o_cpc), 32'd21);

    for (int i = 0; i < 5; i++)
      instr("ssy5", 0, 0, 1, 0, 3'b000, 8'h33,
            NZNP, 0);
    chk("tp_ovfd", 32'(o_depth), 32'd4);
    chk("tp_ovf", 32'(o_ovf), 32'd1);
    chk("tp_ovfpc", 32'(o_cpc), 32'd26);
    instr("brfull", 1, 0, 0, 0, 3'b100, 8'h40,
          NZNP, 0);

    do_reset("rst2");
    instr("udf", 0, 0, 0, 1, 3'b000, 8'h00,
          NZNP, 0);
    chk("tp_udf", 32'(o_udf), 32'd1);
    chk("tp_udfpc", 32'(o_cpc), 32'd1);

    instr("jwrap", 0, 1, 0, 0, 3'b000, 8'hff,
          NZNP, 0);
    dflt("wrap");
    chk("tp_wrap", 32'(o_cpc), 32'd0);

    do_reset("rst3");
    instr("ssyb", 0, 0, 1, 0, 3'b000, 8'd9,
          NZNP, 0);
    instr("brb", 1, 0, 0, 0, 3'b100, 8'd7,
          NZNP, 0);
    chk("tp_d2", 32'(o_depth), 32'd2);
    d_sy = 1'b1;
    cs = 4'b0110;
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk_all("async");
    cs = 4'h0;
    d_sy = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    instr("psync", 0, 0, 0, 1, 3'b000, 8'h00,
          NZNP, 0);
    chk("tp_pudf", 32'(o_udf), 32'd1);

    do_reset("rst4");
    for (int n = 0; n < 400; n++) begin
      instr("rnd",
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            3'($urandom), 8'($urandom),
            12'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
